// File: rtl/mac_burst_arbiter_if.sv
// Bus bundle between the two operand producers, the arbiter and the multiply-add datapath.
interface mac_burst_arbiter_if #(
    parameter int unsigned W = 32
);
    logic [1:0]   req;
    logic [W-1:0] op_a0;
    logic [W-1:0] op_b0;
    logic [W-1:0] op_c0;
    logic [W-1:0] op_a1;
    logic [W-1:0] op_b1;
    logic [W-1:0] op_c1;
    logic [1:0]   gnt;
    logic [1:0]   done;
    logic [W-1:0] result;
    logic         err;
    logic         busy;
    logic         validi;
    logic [W-1:0] data_in;
    logic         valido;
    logic [W-1:0] data_out;

    // Arbiter side
    modport slave (
        input  req, op_a0, op_b0, op_c0, op_a1, op_b1, op_c1, valido, data_out,
        output gnt, done, result, err, busy, validi, data_in
    );

    // Requester/datapath side
    modport master (
        output req, op_a0, op_b0, op_c0, op_a1, op_b1, op_c1, valido, data_out,
        input  gnt, done, result, err, busy, validi, data_in
    );
endinterface

// File: rtl/mac_burst_arbiter.sv
// Round-robin two-port arbiter that streams one operand triple into the
// multiply-add datapath and returns the result (or a timeout) to the winner.
module mac_burst_arbiter #(
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 4
) (
    input logic                clk,
    input logic                rst,
    mac_burst_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEND_A = 3'd1,
        S_SEND_B = 3'd2,
        S_SEND_C = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic             win_q, win_d;
    logic             last_q, last_d;
    logic [W-1:0]     opa_q, opa_d;
    logic [W-1:0]     opb_q, opb_d;
    logic [W-1:0]     opc_q, opc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             validi_q, validi_d;
    logic [W-1:0]     data_in_q, data_in_d;
    logic [W-1:0]     result_q, result_d;
    logic             pick;

    function automatic logic [1:0] onehot(input logic w);
        return w ? 2'b10 : 2'b01;
    endfunction

    // Single request wins outright; a tie goes to whoever was not served last.
    always_comb begin
        pick = bus.req[1];
        if (bus.req == 2'b11) begin
            pick = ~last_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            win_q     <= 1'b0;
            last_q    <= 1'b1;
            opa_q     <= '0;
            opb_q     <= '0;
            opc_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            validi_q  <= 1'b0;
            data_in_q <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            last_q    <= last_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            opc_q     <= opc_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            validi_q  <= validi_d;
            data_in_q <= data_in_d;
            result_q  <= result_d;
        end
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        last_d    = last_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        opc_d     = opc_q;
        cnt_d     = '0;
        gnt_d     = gnt_q;
        done_d    = '0;
        err_d     = 1'b0;
        validi_d  = 1'b0;
        data_in_d = '0;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    win_d     = pick;
                    opa_d     = pick ? bus.op_a1 : bus.op_a0;
                    opb_d     = pick ? bus.op_b1 : bus.op_b0;
                    opc_d     = pick ? bus.op_c1 : bus.op_c0;
                    gnt_d     = onehot(pick);
                    validi_d  = 1'b1;
                    data_in_d = opa_d;
                    state_d   = S_SEND_A;
                end
            end
            S_SEND_A: begin
                validi_d  = 1'b1;
                data_in_d = opb_q;
                state_d   = S_SEND_B;
            end
            S_SEND_B: begin
                validi_d  = 1'b1;
                data_in_d = opc_q;
                state_d   = S_SEND_C;
            end
            S_SEND_C: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.valido) begin
                    result_d = bus.data_out;
                    done_d   = onehot(win_q);
                    state_d  = S_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    done_d   = onehot(win_q);
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                last_d  = win_q;
                gnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.gnt     = gnt_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.err     = err_q;
    assign bus.busy    = busy_q;
    assign bus.validi  = validi_q;
    assign bus.data_in = data_in_q;
endmodule

// File: tb/tb_mac_burst_arbiter.sv
// Self-checking bench: behavioural multiply-add datapath plus a round-robin reference model.
module tb_mac_burst_arbiter;
    localparam int unsigned W       = 32;
    localparam int unsigned TIMEOUT = 4;

    typedef struct {
        int           cyc;
        logic [W-1:0] d;
    } vrec_t;

    typedef struct {
        int           cyc;
        logic [1:0]   done;
        logic         err;
        logic [W-1:0] res;
        logic [1:0]   gnt;
    } drec_t;

    logic clk = 1'b0;
    logic rst;

    mac_burst_arbiter_if #(.W(W)) bus ();

    mac_burst_arbiter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    vrec_t vq[$];
    drec_t dq[$];
    bit    dp_suppress = 1'b0;
    bit    last_served = 1'b1;
    logic [W-1:0] ma[2];
    logic [W-1:0] mb[2];
    logic [W-1:0] mc[2];

    always @(posedge clk) cyc++;

    // Datapath: a*b+c one cycle after the third consecutive validi
    int           dp_cnt;
    logic [W-1:0] dp_a, dp_b;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_cnt       <= 0;
            bus.valido   <= 1'b0;
            bus.data_out <= '0;
        end else begin
            bus.valido <= 1'b0;
            if (bus.validi) begin
                if (dp_cnt == 0) dp_a <= bus.data_in;
                if (dp_cnt == 1) dp_b <= bus.data_in;
                if (dp_cnt == 2 && !dp_suppress) begin
                    bus.valido   <= 1'b1;
                    bus.data_out <= dp_a * dp_b + bus.data_in;
                end
                dp_cnt <= (dp_cnt == 2) ? 0 : dp_cnt + 1;
            end else begin
                dp_cnt <= 0;
            end
        end
    end

    // Monitor: records data_in stream and completions, checks validi run/gap rules
    int    mon_run = 0;
    int    mon_gap = -1;
    vrec_t mon_v;
    drec_t mon_d;
    always @(negedge clk) begin
        if (rst) begin
            mon_run = 0;
            mon_gap = -1;
        end else begin
            if (bus.validi) begin
                mon_v.cyc = cyc;
                mon_v.d   = bus.data_in;
                vq.push_back(mon_v);
                if (mon_run == 0 && mon_gap >= 0) begin
                    n_tests++;
                    if (mon_gap < 3) begin
                        n_fail++;
                        $display("FAIL validi_gap: got %0d idle cycles, need >= 3", mon_gap);
                    end
                end
                mon_run++;
                mon_gap = 0;
            end else begin
                if (mon_run > 0) begin
                    n_tests++;
                    if (mon_run > 3) begin
                        n_fail++;
                        $display("FAIL validi_run: got %0d cycles, need <= 3", mon_run);
                    end
                end
                mon_run = 0;
                if (mon_gap >= 0) mon_gap++;
            end
            if (bus.done != 2'b00) begin
                mon_d.cyc  = cyc;
                mon_d.done = bus.done;
                mon_d.err  = bus.err;
                mon_d.res  = bus.result;
                mon_d.gnt  = bus.gnt;
                dq.push_back(mon_d);
            end
        end
    end

    function automatic logic [W-1:0] mac(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [W-1:0] c);
        return a * b + c;
    endfunction

    function automatic bit pick(input logic [1:0] r, input bit last);
        if (r == 2'b01) return 1'b0;
        if (r == 2'b10) return 1'b1;
        return !last;
    endfunction

    function automatic logic [1:0] hot(input bit w);
        return w ? 2'b10 : 2'b01;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic set_ops(input bit who, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] c);
        ma[who] = a;
        mb[who] = b;
        mc[who] = c;
        if (who) begin
            bus.op_a1 = a; bus.op_b1 = b; bus.op_c1 = c;
        end else begin
            bus.op_a0 = a; bus.op_b0 = b; bus.op_c0 = c;
        end
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        bus.req = 2'b00;
        repeat (2) tick();
        rst         = 1'b0;
        last_served = 1'b1;
        tick();
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy && k < 50) begin
            tick();
            k++;
        end
    endtask

    task automatic start(input logic [1:0] r, output int t0);
        t0 = cyc;
        vq.delete();
        dq.delete();
        bus.req = r;
    endtask

    // Bounded wait for n completions; optionally drops the served request bit
    task automatic wait_dones(input int n, input int budget, input bit drop, output bit ok);
        int k = 0;
        ok = 1'b0;
        while (k < budget) begin
            tick();
            k++;
            if (drop && bus.done != 2'b00) bus.req = bus.req & ~bus.done;
            if (dq.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b, expected 00", bus.gnt); end
        n_tests++; if (bus.done !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b, expected 00", bus.done); end
        n_tests++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b, expected 0", bus.err); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
        n_tests++; if (bus.validi !== 1'b0) begin n_fail++; $display("FAIL reset_validi: got %b, expected 0", bus.validi); end
        n_tests++; if (bus.data_in !== '0) begin n_fail++; $display("FAIL reset_data_in: got %0d, expected 0", bus.data_in); end
        n_tests++; if (bus.result !== '0) begin n_fail++; $display("FAIL reset_result: got %0d, expected 0", bus.result); end
    endtask

    task automatic test_single();
        int t0;
        bit ok;
        logic [W-1:0] exp_d[3];
        wait_idle();
        set_ops(0, 3, 4, 5);
        exp_d[0] = 3; exp_d[1] = 4; exp_d[2] = 5;
        start(2'b01, t0);
        wait_dones(1, 20, 0, ok);
        bus.req = 2'b00;
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL single_timeout: no done within 20 cycles, expected one");
        end else begin
            n_tests++;
            if (vq.size() != 3) begin
                n_fail++; $display("FAIL single_validi_len: got %0d, expected 3", vq.size());
            end else begin
                for (int i = 0; i < 3; i++) begin
                    n_tests++;
                    if (vq[i].d !== exp_d[i] || vq[i].cyc != t0 + 1 + i) begin
                        n_fail++;
                        $display("FAIL single_data_in%0d: got %0d@%0d, expected %0d@%0d", i, vq[i].d, vq[i].cyc, exp_d[i], t0 + 1 + i);
                    end
                end
            end
            n_tests++; if (dq[0].cyc != t0 + 5) begin n_fail++; $display("FAIL single_latency: got t+%0d, expected t+5", dq[0].cyc - t0); end
            n_tests++; if (dq[0].done !== 2'b01) begin n_fail++; $display("FAIL single_done: got %b, expected 01", dq[0].done); end
            n_tests++; if (dq[0].res !== 17) begin n_fail++; $display("FAIL single_result: got %0d, expected 17", dq[0].res); end
            n_tests++; if (dq[0].err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b, expected 0", dq[0].err); end
            tick();
            n_tests++;
            if (bus.result !== 17 || bus.done !== 2'b00 || bus.busy !== 1'b0) begin
                n_fail++; $display("FAIL single_after: got result=%0d done=%b busy=%b, expected 17 00 0", bus.result, bus.done, bus.busy);
            end
        end
        last_served = 1'b0;
    endtask

    task automatic test_tie();
        int t0;
        bit ok;
        apply_reset();
        set_ops(0, 2, 3, 1);
        set_ops(1, 10, 10, 7);
        start(2'b11, t0);
        wait_dones(2, 40, 1, ok);
        bus.req = 2'b00;
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL tie_timeout: got %0d dones, expected 2", dq.size());
        end else begin
            n_tests++;
            if (dq[0].done !== hot(pick(2'b11, last_served)) || dq[0].res !== 7) begin
                n_fail++; $display("FAIL tie_first: got done=%b res=%0d, expected 01 7", dq[0].done, dq[0].res);
            end
            n_tests++;
            if (dq[1].done !== 2'b10 || dq[1].res !== 107) begin
                n_fail++; $display("FAIL tie_second: got done=%b res=%0d, expected 10 107", dq[1].done, dq[1].res);
            end
            n_tests++;
            if (vq.size() != 6) begin
                n_fail++; $display("FAIL tie_validi_len: got %0d, expected 6", vq.size());
            end else if (vq[3].cyc - vq[2].cyc - 1 < 3) begin
                n_fail++; $display("FAIL tie_gap: got %0d, expected >= 3", vq[3].cyc - vq[2].cyc - 1);
            end
        end
        last_served = 1'b1;
    endtask

    task automatic test_alternate();
        int t0;
        bit ok;
        bit w;
        wait_idle();
        set_ops(0, $urandom_range(0, 1000), $urandom_range(0, 1000), $urandom_range(0, 1000));
        set_ops(1, $urandom, $urandom, $urandom);
        start(2'b11, t0);
        wait_dones(4, 60, 0, ok);
        bus.req = 2'b00;
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL alt_timeout: got %0d dones, expected 4", dq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                w = pick(2'b11, last_served);
                n_tests++;
                if (dq[i].done !== hot(w) || dq[i].gnt !== hot(w) || dq[i].res !== mac(ma[w], mb[w], mc[w])
                    || dq[i].cyc != t0 + 5 + 6 * i) begin
                    n_fail++;
                    $display("FAIL alt_burst%0d: got done=%b gnt=%b res=%0d cyc=t+%0d, expected %b %b %0d t+%0d",
                             i, dq[i].done, dq[i].gnt, dq[i].res, dq[i].cyc - t0, hot(w), hot(w),
                             mac(ma[w], mb[w], mc[w]), 5 + 6 * i);
                end
                last_served = w;
            end
        end
    endtask

    task automatic test_timeout();
        int t0;
        bit ok;
        wait_idle();
        set_ops(0, 6, 7, 8);
        dp_suppress = 1'b1;
        start(2'b01, t0);
        wait_dones(1, 30, 0, ok);
        bus.req = 2'b00;
        dp_suppress = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL tmo_timeout: no done within 30 cycles, expected one");
        end else begin
            n_tests++;
            if (dq[0].cyc != t0 + 4 + TIMEOUT || dq[0].err !== 1'b1 || dq[0].res !== '0 || dq[0].done !== 2'b01) begin
                n_fail++;
                $display("FAIL tmo_completion: got t+%0d err=%b res=%0d done=%b, expected t+%0d 1 0 01",
                         dq[0].cyc - t0, dq[0].err, dq[0].res, dq[0].done, 4 + TIMEOUT);
            end
        end
        last_served = 1'b0;
        tick();
        set_ops(1, 9, 9, 9);
        start(2'b10, t0);
        wait_dones(1, 20, 0, ok);
        bus.req = 2'b00;
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL tmo_next_timeout: no done within 20 cycles, expected one");
        end else begin
            n_tests++;
            if (dq[0].cyc != t0 + 5 || dq[0].err !== 1'b0 || dq[0].res !== 90 || dq[0].done !== 2'b10) begin
                n_fail++;
                $display("FAIL tmo_next: got t+%0d err=%b res=%0d done=%b, expected t+5 0 90 10",
                         dq[0].cyc - t0, dq[0].err, dq[0].res, dq[0].done);
            end
        end
        last_served = 1'b1;
    endtask

    task automatic test_latch();
        int t0;
        bit ok;
        logic [W-1:0] exp_d[3];
        wait_idle();
        set_ops(0, $urandom, $urandom, $urandom);
        exp_d[0] = ma[0]; exp_d[1] = mb[0]; exp_d[2] = mc[0];
        start(2'b01, t0);
        tick();
        tick();
        bus.op_a0 = ~exp_d[0];
        bus.op_b0 = ~exp_d[1];
        bus.op_c0 = ~exp_d[2];
        tick();
        tick();
        bus.req = 2'b00;
        wait_dones(1, 20, 0, ok);
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL latch_timeout: no done within 20 cycles, expected one");
        end else begin
            n_tests++;
            if (vq.size() != 3) begin
                n_fail++; $display("FAIL latch_validi_len: got %0d, expected 3", vq.size());
            end else begin
                for (int i = 0; i < 3; i++) begin
                    n_tests++;
                    if (vq[i].d !== exp_d[i]) begin
                        n_fail++; $display("FAIL latch_data_in%0d: got %0h, expected %0h", i, vq[i].d, exp_d[i]);
                    end
                end
            end
            n_tests++;
            if (dq[0].cyc != t0 + 5 || dq[0].done !== 2'b01 || dq[0].res !== mac(exp_d[0], exp_d[1], exp_d[2])) begin
                n_fail++;
                $display("FAIL latch_result: got t+%0d done=%b res=%0h, expected t+5 01 %0h",
                         dq[0].cyc - t0, dq[0].done, dq[0].res, mac(exp_d[0], exp_d[1], exp_d[2]));
            end
        end
        last_served = 1'b0;
    endtask

    task automatic test_reset_mid();
        int t0;
        int t1;
        bit ok;
        wait_idle();
        set_ops(0, 11, 12, 13);
        start(2'b01, t0);
        tick();
        tick();
        rst     = 1'b1;
        bus.req = 2'b10;
        set_ops(1, 21, 3, 4);
        #1;
        n_tests++;
        if (bus.validi !== 1'b0 || bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 2'b00) begin
            n_fail++;
            $display("FAIL rstmid_immediate: got validi=%b gnt=%b busy=%b done=%b, expected 0 00 0 00",
                     bus.validi, bus.gnt, bus.busy, bus.done);
        end
        repeat (2) tick();
        n_tests++;
        if (dq.size() != 0) begin
            n_fail++; $display("FAIL rstmid_no_done: got %0d dones, expected 0", dq.size());
        end
        last_served = 1'b1;
        rst = 1'b0;
        start(2'b10, t1);
        wait_dones(1, 20, 0, ok);
        bus.req = 2'b00;
        n_tests++;
        if (!ok) begin
            n_fail++; $display("FAIL rstmid_timeout: no done within 20 cycles, expected one");
        end else begin
            n_tests++;
            if (dq[0].cyc != t1 + 5 || dq[0].done !== 2'b10 || dq[0].res !== 67 || dq[0].err !== 1'b0
                || vq.size() == 0 || vq[0].cyc != t1 + 1) begin
                n_fail++;
                $display("FAIL rstmid_after: got t+%0d done=%b res=%0d err=%b, expected t+5 10 67 0",
                         dq[0].cyc - t1, dq[0].done, dq[0].res, dq[0].err);
            end
        end
        last_served = 1'b1;
    endtask

    task automatic test_random();
        int t0;
        bit ok;
        bit w;
        bit sup;
        int exp_lat;
        logic [1:0] r;
        logic [W-1:0] exp_res;
        for (int it = 0; it < 40; it++) begin
            wait_idle();
            r   = 2'($urandom_range(1, 3));
            sup = ($urandom_range(0, 4) == 0);
            set_ops(0, $urandom, $urandom, $urandom);
            set_ops(1, $urandom, $urandom, $urandom);
            w           = pick(r, last_served);
            exp_res     = sup ? '0 : mac(ma[w], mb[w], mc[w]);
            exp_lat     = sup ? 4 + TIMEOUT : 5;
            dp_suppress = sup;
            start(r, t0);
            wait_dones(1, 30, 0, ok);
            bus.req = 2'b00;
            n_tests++;
            if (!ok) begin
                n_fail++; $display("FAIL rand%0d_timeout: no done within 30 cycles, expected one", it);
            end else begin
                if (dq[0].done !== hot(w) || dq[0].gnt !== hot(w) || dq[0].res !== exp_res
                    || dq[0].err !== sup || dq[0].cyc != t0 + exp_lat || vq.size() != 3
                    || vq[0].d !== ma[w] || vq[1].d !== mb[w] || vq[2].d !== mc[w]) begin
                    n_fail++;
                    $display("FAIL rand%0d: got done=%b res=%0h err=%b t+%0d nvalid=%0d, expected %b %0h %b t+%0d 3",
                             it, dq[0].done, dq[0].res, dq[0].err, dq[0].cyc - t0, vq.size(),
                             hot(w), exp_res, sup, exp_lat);
                end
            end
            last_served = w;
        end
        dp_suppress = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        bus.req = 2'b00;
        set_ops(0, '0, '0, '0);
        set_ops(1, '0, '0, '0);
        test_reset();
        test_single();
        test_tie();
        test_alternate();
        test_timeout();
        test_latch();
        test_reset_mid();
        test_random();
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/mac_burst_arbiter.md
# mac_burst_arbiter

Two-port arbiter and sequencer for the three-operand multiply-add datapath, which computes data_out = a*b + c after seeing validi for three consecutive cycles. Each requester presents one operand triple. The block grants the datapath round-robin and streams a, b, c on three consecutive validi cycles. It then forces validi low, captures data_out when valido arrives, and returns the result to the granted requester with a one-cycle done pulse. It sits between the two operand producers and the single datapath instance.

## Interface
- W, 32, operand/result width
- TIMEOUT, 4, max cycles spent in WAIT for valido before an error completion (≥1)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  2  request per requester; held high with operands stable until matching done
- op_a0, op_b0, op_c0  in  W each  requester 0 operands
- op_a1, op_b1, op_c1  in  W each  requester 1 operands
- gnt  out  2  one-hot, high from SEND_A through DONE for the served requester
- done  out  2  one-cycle pulse on the served requester's bit
- result  out  W  captured data_out, valid while done≠0, held afterwards
- err  out  1  high with done when completion was a timeout (result=0)
- busy  out  1  state≠IDLE
- validi  out  1  to datapath
- data_in  out  W  to datapath
- valido  in  1  from datapath
- data_out  in  W  from datapath

## Operation
- States: IDLE, SEND_A, SEND_B, SEND_C, WAIT, DONE.
- IDLE: when any req bit is high, choose the winner. On the edge, latch the winner's a/b/c into internal registers, set gnt, and go to SEND_A.
- Arbitration uses a last-served pointer. A single request wins outright. On simultaneous requests the requester not served last wins. After reset the pointer is set so requester 0 wins the first tie.
- SEND_A, SEND_B and SEND_C drive validi=1 with data_in set to latched a, b and c respectively. Latched operands are used, so operand changes after grant have no effect.
- WAIT: validi=0 and data_in=0.
  - If valido=1, capture data_out into result, set done[winner], and go to DONE.
  - If TIMEOUT WAIT cycles elapse without valido, set done[winner] and err, set result=0, and go to DONE.
  - valido seen in any state other than WAIT is ignored.
- DONE: done/err high for this cycle only. Update the pointer to the winner, clear gnt, and go to IDLE.
- A req drop mid-burst is ignored: the burst completes and done still pulses.
- validi is never high for more than three consecutive cycles. At least three validi=0 cycles (WAIT, DONE, IDLE) separate bursts.
- Arithmetic is performed by the datapath only. The block passes W-bit values through unchanged, with no truncation or extension.

## Timing
- All outputs are registered.
- Reset values: state IDLE, gnt=0, done=0, err=0, busy=0, validi=0, data_in=0, result=0, pointer favours requester 0, timeout counter 0.
- Reset asserted mid-burst immediately returns all of the above to reset values. No done pulse is issued for the aborted burst.
- Request sampled high in IDLE at cycle t:
  - gnt and validi high from t+1.
  - data_in = a, b, c at t+1, t+2, t+3.
  - valido expected at t+4.
  - done and result visible at t+5.
  - Back in IDLE at t+6.
  - The next grant's first validi is no earlier than t+7.
- Timeout path: WAIT spans t+4 .. t+3+TIMEOUT, and done/err are visible at t+4+TIMEOUT.
- Per-burst latency, req to done: 5 cycles nominal.

## Test plan
- Single request, req=01 with a0=3, b0=4, c0=5 and the datapath model behaving correctly:
  - validi high t+1..t+3 with data_in 3, 4, 5.
  - done=01 and result=17 at t+5.
  - err=0.
- Simultaneous req=11 right after reset, with requester 0 triple (2, 3, 1) and requester 1 triple (10, 10, 7):
  - Requester 0 is served first and gets result 7.
  - Requester 1 is served next and gets result 107.
  - validi gap between the bursts ≥3 cycles.
- req held at 11 continuously: grants strictly alternate 01, 10, 01, 10 over four bursts.
- Datapath model suppresses valido with TIMEOUT=4: done pulses at t+8 with err=1 and result=0. The next request proceeds normally.
- Operands of the served requester change during SEND_B, and req drops during WAIT: data_in still streams the latched triple, and done still pulses with the correct result.
- rst asserted during SEND_B: validi, gnt and busy drop to 0 immediately with no done. After release, a pending req=10 is granted normally.
